// File: rtl/uart_tx_queue_if.sv
// Bundles the producer handshake and the simple_uart launch signals of uart_tx_queue.
// Producer side is valid/ready: a byte moves on a rising edge where in_valid && in_ready.
interface uart_tx_queue_if;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;
    logic       uart_transmit;
    logic [7:0] uart_tx_byte;
    logic       uart_is_transmitting;

    modport slave (
        input  in_valid,
        input  in_byte,
        output in_ready,
        output uart_transmit,
        output uart_tx_byte,
        input  uart_is_transmitting
    );

    modport master (
        output in_valid,
        output in_byte,
        input  in_ready,
        input  uart_transmit,
        input  uart_tx_byte,
        output uart_is_transmitting
    );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO plus launch sequencer for simple_uart: one transmit pulse per byte,
// and the head is popped only once the UART reports that the frame has started.
module uart_tx_queue #(
    parameter int ADDR_WIDTH    = 4,
    parameter int START_TIMEOUT = 16,
    parameter int GAP_CYCLES    = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    uart_tx_queue_if.slave        bus,
    input  logic                  overflow_clear,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  overflow,
    output logic                  start_error,
    output logic [2:0]            dbg_state
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int TW    = $clog2(START_TIMEOUT + 1);
    localparam int GW    = $clog2(GAP_CYCLES + 2);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LAUNCH     = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_DONE  = 3'd3,
        S_GAP        = 3'd4
    } state_t;

    state_t                state_q;
    logic [7:0]            mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   fill_q, fill_d;
    logic                  overflow_q, overflow_d;
    logic                  start_error_q;
    logic                  transmit_q;
    logic [7:0]            tx_byte_q;
    logic [TW-1:0]         timer_q;
    logic [GW-1:0]         gap_q;

    logic full;
    logic push;
    logic pop;

    // Fullness comes from the registered count, so a same-cycle pop never frees a slot.
    assign full = (fill_q == (ADDR_WIDTH+1)'(DEPTH));
    assign push = bus.in_valid && !full;
    assign pop  = (state_q == S_WAIT_START) && bus.uart_is_transmitting;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
        if (bus.in_valid && full) overflow_d = 1'b1;
        else if (overflow_clear)  overflow_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= bus.in_byte;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            transmit_q    <= 1'b0;
            tx_byte_q     <= 8'h00;
            timer_q       <= '0;
            gap_q         <= '0;
            start_error_q <= 1'b0;
        end else begin
            transmit_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fill_q != '0 && !bus.uart_is_transmitting) begin
                        tx_byte_q <= mem_q[rd_ptr_q];
                        state_q   <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    transmit_q <= 1'b1;
                    timer_q    <= '0;
                    state_q    <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    // A timeout leaves the head in place so the same byte is relaunched.
                    if (bus.uart_is_transmitting) begin
                        state_q <= S_WAIT_DONE;
                    end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
                        start_error_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.uart_is_transmitting) begin
                        gap_q   <= '0;
                        state_q <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_q == GW'(GAP_CYCLES - 1)) state_q <= S_IDLE;
                    else                              gap_q   <= gap_q + 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready      = !full;
    assign bus.uart_transmit = transmit_q;
    assign bus.uart_tx_byte  = tx_byte_q;
    assign fill_count        = fill_q;
    assign overflow          = overflow_q;
    assign start_error       = start_error_q;
    assign dbg_state         = state_q;
endmodule
